// File: rtl/stall_counter_reader.sv
`default_nettype none
// ============================================================================
//  Module  : stall_counter_reader
//  Brief   : Snapshots nine 32-bit stall counters and streams them as a
//            39-byte framed, checksummed byte stream over valid/ready.
//  Revision: 1.0 - initial release
// ============================================================================
module stall_counter_reader #(
    parameter int CLOCK_FREQ = 1000000,
    parameter int SAMPLE_HZ  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         trigger,
    input  logic [287:0] counters_in,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic [15:0]  frame_count,
    output logic         overrun
);

    localparam int         c_PERIOD   = CLOCK_FREQ / SAMPLE_HZ;
    localparam int         c_TIMER_W  = $clog2(c_PERIOD);
    localparam logic [7:0] c_HEADER   = 8'hA5;
    localparam logic [5:0] c_LAST_IDX = 6'd35;

    if (c_PERIOD < 40) begin : g_period_check
        $error("stall_counter_reader: CLOCK_FREQ/SAMPLE_HZ must be at least 40");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_SEQ    = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [287:0]           r_shadow;
    logic [5:0]             r_idx, w_idx_nx;
    logic [7:0]             r_csum, w_csum_nx;
    logic [7:0]             r_seq;
    logic [15:0]            r_frame_count;
    logic [7:0]             r_tx_data, w_data_nx;
    logic                   r_tx_valid, w_valid_nx;
    logic                   r_overrun;
    logic                   w_tick, w_request, w_hs, w_snap, w_frame_done;

    // Data byte i is byte (3 - i%4) of counter i/4, so each counter goes MSB first.
    function automatic logic [7:0] f_byte(input logic [287:0] s, input logic [5:0] i);
        logic [8:0] base;
        base = {i[5:2], 5'b0} + {4'b0, ~i[1:0], 3'b0};
        return s[base +: 8];
    endfunction

    assign w_tick    = enable && (r_timer == c_TIMER_W'(c_PERIOD - 1));
    assign w_request = enable && (w_tick || trigger);
    assign w_hs      = r_tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (!enable) begin
            r_overrun <= 1'b0;
        end else if (w_request && busy) begin
            r_overrun <= 1'b1;
        end
    end

    // Next-state and next-output: each transition also selects the byte presented next cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_csum_nx    = r_csum;
        w_data_nx    = r_tx_data;
        w_valid_nx   = r_tx_valid;
        w_snap       = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_request) begin
                    w_state_nx = S_HEADER;
                    w_snap     = 1'b1;
                    w_idx_nx   = '0;
                    w_csum_nx  = '0;
                    w_data_nx  = c_HEADER;
                    w_valid_nx = 1'b1;
                end
            end
            S_HEADER: begin
                if (w_hs) begin
                    w_state_nx = S_SEQ;
                    w_csum_nx  = r_seq;
                    w_data_nx  = r_seq;
                end
            end
            S_SEQ: begin
                if (w_hs) begin
                    w_state_nx = S_DATA;
                    w_idx_nx   = '0;
                    w_data_nx  = f_byte(r_shadow, 6'd0);
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    w_csum_nx = r_csum ^ r_tx_data;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nx = S_CSUM;
                        w_data_nx  = r_csum ^ r_tx_data;
                    end else begin
                        w_idx_nx  = r_idx + 6'd1;
                        w_data_nx = f_byte(r_shadow, r_idx + 6'd1);
                    end
                end
            end
            S_CSUM: begin
                if (w_hs) begin
                    w_state_nx   = S_IDLE;
                    w_data_nx    = '0;
                    w_valid_nx   = 1'b0;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_data_nx  = '0;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_csum        <= '0;
            r_seq         <= '0;
            r_frame_count <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_csum     <= w_csum_nx;
            r_tx_data  <= w_data_nx;
            r_tx_valid <= w_valid_nx;
            if (w_frame_done) begin
                r_seq         <= r_seq + 8'd1;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // The shadow is only written when leaving IDLE, so a frame never sees counter updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_snap) begin
            r_shadow <= counters_in;
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = (r_state != S_IDLE);
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
